mmio_router: RTL and testbench
==============================

Name: mmio_router

Overview:
- Parametrised data-side memory-map router between the core dmem port and N slave devices (main memory, TFT text buffer, future peripherals).
- Decodes each access by base/mask, steers byte lanes, and splits multi-byte stores into byte-wide devices into sequential byte writes, stalling the core meanwhile.
- Owns the sticky exit register that ends simulation/test runs, plus an unmapped-access error log.

Parameters:
- N_SLAVES, 2, number of slave ports.
- SLAVE_BASE, {32'h2000_0000, 32'h0000_0000}, packed N×32 base addresses; slave i occupies bits [32i+31:32i].
- SLAVE_MASK, {32'hF000_0000, 32'hE000_0000}, packed N×32 decode masks.
- BYTE_WIDE, 2'b10, bit i set means slave i accepts only 8-bit writes on lane 0.
- EXIT_ADDR, 32'h600D_600C, write-only exit register address.
- ERR_CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- m_valid  in  1  access valid this cycle.
- m_addr  in  32  byte address.
- m_data_i  in  32  store data.
- m_data_en  in  4  byte-lane enables.
- m_write_en  in  1  store when high, load when low.
- m_data_o  out  32  load data, valid the cycle after the load.
- m_stall  out  1  core must hold all m_* inputs while high.
- s_addr  out  N*32  per-slave region offset (m_addr − SLAVE_BASE[i], plus lane index for byte-wide slaves).
- s_data_i  out  N*32  per-slave store data.
- s_data_en  out  N*4  per-slave lane enables.
- s_write_en  out  N  per-slave write strobe.
- s_data_o  in  N*32  per-slave synchronous read data.
- done  out  1  sticky exit flag.
- exit_code  out  32  data written to EXIT_ADDR.
- err_count  out  ERR_CNT_W  number of unmapped accesses.
- err_addr  out  32  address of the most recent unmapped access.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, sel_q = none. Reset mid-split returns to IDLE immediately; no further byte writes are issued.
- Decode: slave i hits when (m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]. The lowest index wins on overlap. An m_addr equal to EXIT_ADDR overrides all slaves.
- Only the selected slave gets s_write_en / s_data_en. All other slaves' strobes are 0. s_write_en never asserts without m_valid.
- Word slave: address offset, data, and data_en pass through unchanged in the same cycle (combinational).
- Byte-wide slave, one-hot m_data_en at lane k: single cycle. s_data_i[7:0] = m_data_i[8k+7:8k], s_addr = offset + k, s_data_en = 4'b0001.
- Byte-wide slave, m_data_en == 0: no write, no stall.
- Byte-wide slave, more than one lane set: FSM IDLE → SPLIT.
  - In SPLIT, one byte is written per cycle in ascending lane order.
  - The first byte is issued combinationally in the accept cycle.
  - m_stall is high from the accept cycle until the cycle the last byte is issued; m_stall is low in that last cycle.
  - Then the FSM returns to IDLE. A 4-lane store takes 4 cycles with 3 stall cycles.
- Loads: sel_q is registered on a valid load. Next cycle, m_data_o = s_data_o[sel_q].
  - Byte-wide slaves return byte 0 replicated across all 4 lanes.
  - Unmapped loads or an EXIT_ADDR load return 32'h0.
  - Loads never stall.
- Exit: a valid store to EXIT_ADDR sets done and latches exit_code = m_data_i on the next edge.
  - The store is not forwarded to any slave.
  - Later exit writes update exit_code; done stays set until reset.
- Error: a valid access that hits no slave and is not EXIT_ADDR increments err_count (saturating at all-ones) and captures err_addr, both on the next edge.

Optional Feature:
- Macro MMIO_ROUTER_ERR_EN.
- Defined: the error counter and address capture behave as above.
- Undefined: err_count and err_addr are tied to 0, no error logic is synthesised, and unmapped accesses are silently dropped. Routing is otherwise unchanged.

Test Plan:
- Store to 0x0000_0100, data 0xAABBCCDD, en 4'b1111 → slave0 write same cycle: addr 0x100, data 0xAABBCCDD, en 4'b1111; m_stall stays 0.
- Store to 0x2000_0010, en 4'b0100, data 0x00EE0000 → slave1: addr 0x12, data[7:0] 0xEE, en 4'b0001; single cycle.
- Store to 0x2000_0020, en 4'b1111, data 0x44332211 → slave1 writes (0x20,0x11), (0x21,0x22), (0x22,0x33), (0x23,0x44) on consecutive cycles; m_stall high for the first 3 cycles.
- Load 0x0000_0040 with slave0 returning 0x12345678 next cycle → m_data_o = 0x12345678 one cycle after the request; slave1 load of byte 0x5A → 0x5A5A5A5A.
- Store 0x0000_002A to 0x600D_600C → done = 1, exit_code = 0x2A; no s_write_en asserted; a subsequent reset clears both.
- With MMIO_ROUTER_ERR_EN, load 0x4000_0000 twice → err_count = 2, err_addr = 0x4000_0000, m_data_o = 0. Assert reset during the 2nd byte of a split → no further byte writes, m_stall 0.

Source files
------------

// File: rtl/mmio_router_if.sv
// Core dmem port and per-slave bus bundle for mmio_router.
// slave: router side; master: core plus slave devices (testbench side).
interface mmio_router_if #(
    parameter int unsigned N_SLAVES = 2
) ();
    logic                     m_valid;
    logic [31:0]              m_addr;
    logic [31:0]              m_data_i;
    logic [3:0]               m_data_en;
    logic                     m_write_en;
    logic [31:0]              m_data_o;
    logic                     m_stall;

    logic [N_SLAVES*32-1:0]   s_addr;
    logic [N_SLAVES*32-1:0]   s_data_i;
    logic [N_SLAVES*4-1:0]    s_data_en;
    logic [N_SLAVES-1:0]      s_write_en;
    logic [N_SLAVES*32-1:0]   s_data_o;

    modport slave (
        input  m_valid, m_addr, m_data_i, m_data_en, m_write_en,
        output m_data_o, m_stall,
        output s_addr, s_data_i, s_data_en, s_write_en,
        input  s_data_o
    );

    modport master (
        output m_valid, m_addr, m_data_i, m_data_en, m_write_en,
        input  m_data_o, m_stall,
        input  s_addr, s_data_i, s_data_en, s_write_en,
        output s_data_o
    );
endinterface

// File: rtl/mmio_router.sv
// Data-side memory-map router: base/mask decode, byte-lane steering, store splitting for
// byte-wide slaves, sticky exit register. MMIO_ROUTER_ERR_EN enables the unmapped-access log.
module mmio_router #(
    parameter int unsigned            N_SLAVES   = 2,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h2000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'hF000_0000, 32'hE000_0000},
    parameter logic [N_SLAVES-1:0]    BYTE_WIDE  = 2'b10,
    parameter logic [31:0]            EXIT_ADDR  = 32'h600D_600C,
    parameter int unsigned            ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_router_if.slave         bus,
    output logic                 done,
    output logic [31:0]          exit_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [31:0]          err_addr
);

    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StSplit = 1'b1;

    logic             is_exit;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             sel_byte;

    always_comb begin
        is_exit = (bus.m_addr == EXIT_ADDR);
        hit     = 1'b0;
        hit_idx = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = i[IDX_W-1:0];
            end
        end
        if (is_exit) hit = 1'b0;
        sel_byte = BYTE_WIDE[hit_idx];
    end

    logic [0:0] state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] lanes, lane_oh, lanes_left;
    logic [1:0] lane_k;
    logic       byte_wr;
    logic       stall;

    // While splitting, the core holds its inputs; rem_q tracks lanes not yet written.
    always_comb begin
        lanes  = (state_q == StSplit) ? rem_q : bus.m_data_en;
        lane_k = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (lanes[j]) lane_k = j[1:0];
        end
        lane_oh    = 4'b0001 << lane_k;
        lanes_left = lanes & ~lane_oh;
        byte_wr    = bus.m_valid && bus.m_write_en && hit && sel_byte && (lanes != 4'b0000)
                     && !reset;
        stall      = byte_wr && (lanes_left != 4'b0000);
        state_d    = stall ? StSplit : StIdle;
        rem_d      = stall ? lanes_left : 4'b0000;
    end

    logic [N_SLAVES*32-1:0] s_addr;
    logic [N_SLAVES*32-1:0] s_data_i;
    logic [N_SLAVES*4-1:0]  s_data_en;
    logic [N_SLAVES-1:0]    s_write_en;

    always_comb begin
        logic [31:0] off;
        logic        sel;
        s_addr     = '0;
        s_data_i   = '0;
        s_data_en  = '0;
        s_write_en = '0;
        off        = '0;
        sel        = 1'b0;
        if (!reset) begin
            for (int i = 0; i < int'(N_SLAVES); i++) begin
                off = bus.m_addr - SLAVE_BASE[32*i +: 32];
                sel = hit && (hit_idx == i[IDX_W-1:0]) && bus.m_valid;
                if (BYTE_WIDE[i]) begin
                    s_addr[32*i +: 32]  = off + {30'b0, lane_k};
                    s_data_i[32*i +: 32] = {24'b0, bus.m_data_i[{lane_k, 3'b000} +: 8]};
                    s_data_en[4*i +: 4]  = (sel && lanes != 4'b0000) ? 4'b0001 : 4'b0000;
                    s_write_en[i]        = sel && bus.m_write_en && (lanes != 4'b0000);
                end else begin
                    s_addr[32*i +: 32]   = off;
                    s_data_i[32*i +: 32] = bus.m_data_i;
                    s_data_en[4*i +: 4]  = sel ? bus.m_data_en : 4'b0000;
                    s_write_en[i]        = sel && bus.m_write_en;
                end
            end
        end
    end

    assign bus.s_addr     = s_addr;
    assign bus.s_data_i   = s_data_i;
    assign bus.s_data_en  = s_data_en;
    assign bus.s_write_en = s_write_en;
    assign bus.m_stall    = stall;

    logic             sel_vld_q;
    logic [IDX_W-1:0] sel_idx_q;
    logic [31:0]      rd_word;
    logic             done_q;
    logic [31:0]      exit_code_q;
    logic             exit_wr;

    assign exit_wr = bus.m_valid && bus.m_write_en && is_exit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rem_q       <= 4'b0000;
            sel_vld_q   <= 1'b0;
            sel_idx_q   <= '0;
            done_q      <= 1'b0;
            exit_code_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sel_vld_q <= bus.m_valid && !bus.m_write_en && hit;
            sel_idx_q <= hit_idx;
            if (exit_wr) begin
                done_q      <= 1'b1;
                exit_code_q <= bus.m_data_i;
            end
        end
    end

    // Byte-wide slaves only drive lane 0; replicate it so any lane the core picks is right.
    always_comb begin
        rd_word      = bus.s_data_o[{sel_idx_q, 5'b00000} +: 32];
        bus.m_data_o = 32'h0;
        if (sel_vld_q) begin
            bus.m_data_o = BYTE_WIDE[sel_idx_q] ? {4{rd_word[7:0]}} : rd_word;
        end
    end

    assign done      = done_q;
    assign exit_code = exit_code_q;

`ifdef MMIO_ROUTER_ERR_EN
    logic                 unmapped;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic [31:0]          err_addr_q;

    assign unmapped = bus.m_valid && !hit && !is_exit;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
            err_addr_q  <= 32'h0;
        end else if (unmapped) begin
            if (err_count_q != '1) err_count_q <= err_count_q + ERR_CNT_W'(1);
            err_addr_q <= bus.m_addr;
        end
    end

    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;
`else
    assign err_count = '0;
    assign err_addr  = 32'h0;
`endif

endmodule

// File: tb/tb_mmio_router.sv
// Scoreboard bench for mmio_router: stimulus pushes expected slave writes and load data,
// a negedge monitor pops and compares against what the router presents.
module tb_mmio_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done;
    logic [31:0] exit_code;
    logic [15:0] err_count;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    mmio_router_if #(.N_SLAVES(2)) bus ();

    mmio_router #(.N_SLAVES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .exit_code (exit_code),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    // Memory map from the block description, kept as plain tables.
    localparam logic [31:0] EXIT = 32'h600D_600C;
    logic [31:0] base_a [2] = '{32'h0000_0000, 32'h2000_0000};
    logic [31:0] mask_a [2] = '{32'hE000_0000, 32'hF000_0000};
    bit          byte_a [2] = '{1'b0, 1'b1};

    typedef struct {
        int          slv;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  en;
        bit          stall;
    } wr_t;
    typedef struct {
        int          due;
        logic [31:0] val;
    } ld_t;

    wr_t wq[$];
    ld_t lq[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          exp_done = 1'b0;
    logic [31:0] exp_code = 32'h0;
    int          exp_err_cnt = 0;
    logic [31:0] exp_err_addr = 32'h0;
    logic [31:0] rd_val [2] = '{32'h0, 32'h0};

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous slave devices: read data appears the cycle after the request.
    always @(posedge clk) bus.s_data_o <= {rd_val[1], rd_val[0]};

    function automatic int decode(input logic [31:0] a);
        if (a == EXIT) return -2;
        for (int i = 0; i < 2; i++) begin
            if ((a & mask_a[i]) == base_a[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    initial begin
        wr_t e;
        ld_t l;
        forever begin
            @(negedge clk);
            if (bus.s_write_en != 2'b00) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", {30'b0, bus.s_write_en}, 32'h0);
                end else begin
                    e = wq.pop_front();
                    check("wr_strobe", {30'b0, bus.s_write_en}, 32'(1) << e.slv);
                    check("wr_addr", bus.s_addr[32*e.slv +: 32], e.addr);
                    if (byte_a[e.slv])
                        check("wr_byte", {24'b0, bus.s_data_i[32*e.slv +: 8]}, e.data);
                    else
                        check("wr_data", bus.s_data_i[32*e.slv +: 32], e.data);
                    check("wr_en", {28'b0, bus.s_data_en[4*e.slv +: 4]}, {28'b0, e.en});
                    check("wr_stall", {31'b0, bus.m_stall}, {31'b0, e.stall});
                end
            end else begin
                check("stall_idle", {31'b0, bus.m_stall}, 32'h0);
            end
            while (lq.size() > 0 && lq[0].due <= cyc) begin
                l = lq.pop_front();
                if (l.due != cyc) check("load_missed", 32'(l.due), 32'(cyc));
                else check("m_data_o", bus.m_data_o, l.val);
            end
            check("done", {31'b0, done}, {31'b0, exp_done});
            check("exit_code", exit_code, exp_code);
            check("err_count", {16'b0, err_count}, 32'(exp_err_cnt));
            check("err_addr", err_addr, exp_err_addr);
        end
    end

    task automatic model_reset();
        exp_done     = 1'b0;
        exp_code     = 32'h0;
        exp_err_cnt  = 0;
        exp_err_addr = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.m_valid = 1'b0;
        @(posedge clk); #1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.m_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // One core access, held while the router stalls.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en,
                          input bit we, input logic [31:0] rdv);
        int s = decode(a);
        int nl = 0;
        int emitted = 0;
        int waits = 0;
        bit st;
        bus.m_valid    = 1'b1;
        bus.m_addr     = a;
        bus.m_data_i   = d;
        bus.m_data_en  = en;
        bus.m_write_en = we;
        if (!we) begin
            rd_val[0] = rdv;
            rd_val[1] = rdv;
            if (s < 0) lq.push_back('{cyc + 1, 32'h0});
            else if (byte_a[s]) lq.push_back('{cyc + 1, {4{rdv[7:0]}}});
            else lq.push_back('{cyc + 1, rdv});
        end else if (s >= 0) begin
            if (!byte_a[s]) begin
                wq.push_back('{s, a - base_a[s], d, en, 1'b0});
            end else begin
                for (int k = 0; k < 4; k++) if (en[k]) nl++;
                for (int k = 0; k < 4; k++) begin
                    if (en[k]) begin
                        emitted++;
                        wq.push_back('{s, a - base_a[s] + 32'(k), {24'b0, d[8*k +: 8]},
                                       4'b0001, emitted < nl});
                    end
                end
            end
        end
        forever begin
            @(negedge clk);
            st = bus.m_stall;
            @(posedge clk); #1;
            if (!st) break;
            waits++;
            if (waits > 6) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stall_timeout: got %0d stall cycles expected at most 3", waits);
                break;
            end
        end
        bus.m_valid = 1'b0;
        if (we && s == -2) begin
            exp_done = 1'b1;
            exp_code = d;
        end
`ifdef MMIO_ROUTER_ERR_EN
        if (s == -1) begin
            if (exp_err_cnt < 65535) exp_err_cnt++;
            exp_err_addr = a;
        end
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  en;
        bit          we;
        int          r;
        bus.m_valid    = 1'b0;
        bus.m_addr     = 32'h0;
        bus.m_data_i   = 32'h0;
        bus.m_data_en  = 4'h0;
        bus.m_write_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_m_data_o", bus.m_data_o, 32'h0);
        check("rst_s_write_en", {30'b0, bus.s_write_en}, 32'h0);
        @(posedge clk); #1;

        access(32'h0000_0100, 32'hAABB_CCDD, 4'b1111, 1'b1, 32'h0);
        access(32'h2000_0010, 32'h00EE_0000, 4'b0100, 1'b1, 32'h0);
        access(32'h2000_0020, 32'h4433_2211, 4'b1111, 1'b1, 32'h0);
        access(32'h2000_0030, 32'h4433_2211, 4'b1010, 1'b1, 32'h0);
        access(32'h2000_0034, 32'h1234_5678, 4'b0000, 1'b1, 32'h0);
        access(32'h0000_0040, 32'h0, 4'b1111, 1'b0, 32'h1234_5678);
        access(32'h2000_0000, 32'h0, 4'b0001, 1'b0, 32'h0000_005A);
        idle(1);
        access(EXIT, 32'h0000_002A, 4'b1111, 1'b1, 32'h0);
        idle(2);
        access(EXIT, 32'h0000_0055, 4'b1111, 1'b1, 32'h0);
        idle(1);
        do_reset();
        idle(1);
        access(32'h4000_0000, 32'h0, 4'b1111, 1'b0, 32'hDEAD_BEEF);
        access(32'h4000_0000, 32'h0, 4'b1111, 1'b0, 32'hDEAD_BEEF);
        idle(1);
`ifdef MMIO_ROUTER_ERR_EN
        check("err_twice_count", {16'b0, err_count}, 32'd2);
        check("err_twice_addr", err_addr, 32'h4000_0000);
`else
        check("err_off_count", {16'b0, err_count}, 32'd0);
        check("err_off_addr", err_addr, 32'h0);
`endif

        // Reset lands on the second byte of a split: nothing after the first byte.
        bus.m_valid    = 1'b1;
        bus.m_addr     = 32'h2000_0020;
        bus.m_data_i   = 32'h4433_2211;
        bus.m_data_en  = 4'b1111;
        bus.m_write_en = 1'b1;
        wq.push_back('{1, 32'h20, 32'h11, 4'b0001, 1'b1});
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.m_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        idle(3);
        check("split_reset_drained", 32'(wq.size()), 32'h0);

        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            en = 4'($urandom_range(0, 15));
            if (r <= 3) begin
                a = $urandom & 32'h1FFF_FFFF;
                if (en == 4'b0000) en = 4'b1111;
            end else if (r <= 6) begin
                a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
            end else if (r == 7) begin
                a = EXIT;
            end else begin
                a = {4'($urandom_range(3, 15)), 28'($urandom)};
            end
            access(a, $urandom, en, we, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(3);
        check("wq_empty", 32'(wq.size()), 32'h0);
        check("lq_empty", 32'(lq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
